// File: rtl/keccak_dom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_dom_pkg
//  Description : Shared constants, FSM encoding and helper functions for the
//                DOM-Keccak masking randomness source.
//                  LFSR_W            LFSR state width (128)
//                  SEED_W/SEED_WORDS TRNG seed word width and words per seed
//                  TAP_*             feedback taps of x^128+x^126+x^101+x^99+1
//                  rs_state_t        randomness source FSM states
//                  z_width()         Z word width for a given share count
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_dom_pkg;

    localparam int LFSR_W     = 128;
    localparam int SEED_W     = 32;
    localparam int SEED_WORDS = LFSR_W / SEED_W;

    // Fibonacci feedback taps, expressed as state bit indices.
    localparam int TAP_A = 127;
    localparam int TAP_B = 125;
    localparam int TAP_C = 100;
    localparam int TAP_D = 98;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_WARM = 3'd2,
        ST_RUN  = 3'd3,
        ST_EXH  = 3'd4
    } rs_state_t;

    // One fresh bit per share pair per chi lane of the 5-bit sbox row.
    function automatic int z_width(input int shares);
        return ((shares * shares - shares) / 2) * 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_lfsr_advance.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_lfsr_advance
//  Description : Combinational multi-step advance of the 128-bit Fibonacci
//                LFSR. Each step shifts toward the MSB and inserts
//                s[127]^s[125]^s[100]^s[98] at bit 0.
//                  StatexDI  in   128  current state
//                  StatexDO  out  128  state after STEPS single steps
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_lfsr_advance
    import keccak_dom_pkg::*;
#(
    parameter int STEPS = 50
) (
    input  logic [LFSR_W-1:0] StatexDI,
    output logic [LFSR_W-1:0] StatexDO
);

    always_comb begin : p_unroll
        logic [LFSR_W-1:0] w_state;
        w_state = StatexDI;
        for (int i = 0; i < STEPS; i++) begin
            w_state = {w_state[LFSR_W-2:0],
                       w_state[TAP_A] ^ w_state[TAP_B] ^ w_state[TAP_C] ^ w_state[TAP_D]};
        end
        StatexDO = w_state;
    end

endmodule
`default_nettype wire

// File: rtl/keccak_dom_rand_src.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_dom_rand_src
//  Description : Fresh masking randomness for the DOM-masked Keccak chi layer.
//                A 128-bit LFSR is seeded from four TRNG words, warmed up, then
//                advanced Z_W steps for every Z word taken by the consumer.
//                A forced reseed is requested after RESEED_INTERVAL words.
//                  ClkxCI        in   1    clock, rising edge
//                  RstxRBI       in   1    asynchronous active-low reset
//                  SeedxDI       in   32   seed word from TRNG
//                  SeedValidxSI  in   1    seed word valid
//                  SeedReadyxSO  out  1    seed word accepted when valid
//                  ReseedxSI     in   1    reseed request (level)
//                  ZxDO          out  Z_W  randomness word (register slice)
//                  ZValidxSO     out  1    ZxDO valid
//                  ZReadyxSI     in   1    consumer takes ZxDO
//                  ReseedReqxSO  out  1    word budget exhausted, seed needed
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_dom_rand_src
    import keccak_dom_pkg::*;
#(
    parameter int SHARES          = 5,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 4096,
    localparam int Z_W            = z_width(SHARES)
) (
    input  logic              ClkxCI,
    input  logic              RstxRBI,
    input  logic [SEED_W-1:0] SeedxDI,
    input  logic              SeedValidxSI,
    output logic              SeedReadyxSO,
    input  logic              ReseedxSI,
    output logic [Z_W-1:0]    ZxDO,
    output logic              ZValidxSO,
    input  logic              ZReadyxSI,
    output logic              ReseedReqxSO
);

    localparam int WU_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int OC_W = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

    localparam logic [WU_W-1:0] c_WU_LAST  = WU_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [OC_W:0]   c_OC_LIMIT = (OC_W + 1)'(RESEED_INTERVAL);
    localparam logic [1:0]      c_WC_LAST  = 2'(SEED_WORDS - 1);

    rs_state_t         r_state, w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr,  w_lfsr_nxt;
    logic [1:0]        r_wcnt,  w_wcnt_nxt;
    logic [WU_W-1:0]   r_wucnt, w_wucnt_nxt;
    logic [OC_W-1:0]   r_ocnt,  w_ocnt_nxt;

    logic [LFSR_W-1:0] w_lfsr_adv;
    logic [LFSR_W-1:0] w_seed_mix;
    logic [1:0]        w_slot;
    logic              w_hs;
    logic [OC_W:0]     w_ocnt_sum;

    keccak_lfsr_advance #(
        .STEPS (Z_W)
    ) u_adv (
        .StatexDI (r_lfsr),
        .StatexDO (w_lfsr_adv)
    );

    // Seed words are XORed into their slot so a reseed mixes with the old
    // state instead of replacing it. After reset the state is zero, so the
    // first seeding is a plain load. IDLE and EXH always start at slot 0.
    assign w_slot     = (r_state == ST_SEED) ? r_wcnt : 2'd0;
    assign w_seed_mix = r_lfsr ^ ({{(LFSR_W - SEED_W){1'b0}}, SeedxDI} << {w_slot, 5'b0});

    assign w_hs       = (r_state == ST_RUN) && ZReadyxSI;
    assign w_ocnt_sum = {1'b0, r_ocnt} + (OC_W + 1)'(w_hs);

    // Output word is a plain slice of the state register.
    assign ZxDO = r_lfsr[Z_W-1:0];

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            r_state <= ST_IDLE;
            r_lfsr  <= '0;
            r_wcnt  <= '0;
            r_wucnt <= '0;
            r_ocnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_wucnt <= w_wucnt_nxt;
            r_ocnt  <= w_ocnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_wcnt_nxt   = r_wcnt;
        w_wucnt_nxt  = r_wucnt;
        w_ocnt_nxt   = r_ocnt;
        SeedReadyxSO = 1'b0;
        ZValidxSO    = 1'b0;
        ReseedReqxSO = 1'b0;

        case (r_state)
            ST_IDLE, ST_EXH: begin
                SeedReadyxSO = 1'b1;
                ReseedReqxSO = (r_state == ST_EXH);
                if (SeedValidxSI) begin
                    w_lfsr_nxt  = w_seed_mix;
                    w_wcnt_nxt  = 2'd1;
                    w_state_nxt = ST_SEED;
                end
            end

            ST_SEED: begin
                SeedReadyxSO = 1'b1;
                if (SeedValidxSI) begin
                    if (r_wcnt == c_WC_LAST) begin
                        // An all-zero state would lock the LFSR up forever.
                        w_lfsr_nxt  = (w_seed_mix == '0) ? {{(LFSR_W - 1){1'b0}}, 1'b1}
                                                         : w_seed_mix;
                        w_wcnt_nxt  = 2'd0;
                        w_wucnt_nxt = '0;
                        w_ocnt_nxt  = '0;
                        w_state_nxt = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARM;
                    end else begin
                        w_lfsr_nxt = w_seed_mix;
                        w_wcnt_nxt = r_wcnt + 2'd1;
                    end
                end
            end

            ST_WARM: begin
                w_lfsr_nxt  = w_lfsr_adv;
                w_wucnt_nxt = r_wucnt + WU_W'(1);
                if (r_wucnt == c_WU_LAST) begin
                    w_ocnt_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                ZValidxSO = 1'b1;
                if (w_hs) begin
                    w_lfsr_nxt = w_lfsr_adv;
                    w_ocnt_nxt = w_ocnt_sum[OC_W-1:0];
                end
                // A reseed request wins over budget exhaustion; the handshake
                // in the same cycle still completes.
                if (ReseedxSI) begin
                    w_wcnt_nxt  = 2'd0;
                    w_state_nxt = ST_SEED;
                end else if ((RESEED_INTERVAL != 0) && (w_ocnt_sum == c_OC_LIMIT)) begin
                    w_state_nxt = ST_EXH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_dom_rand_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_dom_rand_src
//  Description : Self-checking bench for keccak_dom_rand_src. Two instances:
//                d0 (no warmup, no forced reseed) and d1 (warmup 5, reseed
//                every 3 words). A reference model tracks the LFSR state from
//                the polynomial and the seeding/handshake rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_dom_rand_src;

    localparam int ZW = 50;
    localparam int W1 = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed [2];
    logic        sv   [2];
    logic        sr   [2];
    logic        rs   [2];
    logic [ZW-1:0] z  [2];
    logic        zv   [2];
    logic        zr   [2];
    logic        rq   [2];

    logic [127:0] m [2];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    keccak_dom_rand_src #(.SHARES(5), .WARMUP_CYCLES(0), .RESEED_INTERVAL(0)) u_d0 (
        .ClkxCI(clk), .RstxRBI(rst_n),
        .SeedxDI(seed[0]), .SeedValidxSI(sv[0]), .SeedReadyxSO(sr[0]),
        .ReseedxSI(rs[0]), .ZxDO(z[0]), .ZValidxSO(zv[0]), .ZReadyxSI(zr[0]),
        .ReseedReqxSO(rq[0]));

    keccak_dom_rand_src #(.SHARES(5), .WARMUP_CYCLES(W1), .RESEED_INTERVAL(3)) u_d1 (
        .ClkxCI(clk), .RstxRBI(rst_n),
        .SeedxDI(seed[1]), .SeedValidxSI(sv[1]), .SeedReadyxSO(sr[1]),
        .ReseedxSI(rs[1]), .ZxDO(z[1]), .ZValidxSO(zv[1]), .ZReadyxSI(zr[1]),
        .ReseedReqxSO(rq[1]));

    // Reference: polynomial x^128+x^126+x^101+x^99+1, one Z word = ZW steps.
    function automatic logic [127:0] step1(input logic [127:0] s);
        int   taps [4] = '{127, 125, 100, 98};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]];
        return {s[126:0], fb};
    endfunction

    function automatic logic [127:0] adv(input logic [127:0] s, input int words);
        logic [127:0] t = s;
        for (int i = 0; i < words * ZW; i++) t = step1(t);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_zvalid"}, zv[d], 1'b0);
            chk({tag, "_seedready"}, sr[d], 1'b1);
            chk({tag, "_reseedreq"}, rq[d], 1'b0);
            chk({tag, "_z"}, z[d], '0);
        end
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must
    // return to their reset values without any clock edge.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; rs[d] = 1'b0; zr[d] = 1'b0; seed[d] = '0;
            m[d] = '0;
        end
    endtask

    // Four seed words, XORed into consecutive 32-bit slots of the state.
    task automatic seed_all(input int d, input logic [31:0] w0, w1, w2, w3);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int k = 0; k < 4; k++) begin
            chk("seed_ready", sr[d], 1'b1);
            seed[d] = w[k];
            sv[d]   = 1'b1;
            tick();
            sv[d]   = 1'b0;
            m[d]    = m[d] ^ ({96'b0, w[k]} << (32 * k));
            if (k < 3) chk("zvalid_during_seed", zv[d], 1'b0);
        end
        if (m[d] == '0) m[d] = 128'h1;
    endtask

    // Called right after the last seed word: ZValid rises after warm cycles.
    task automatic warm_to_run(input int d, input int warm);
        for (int i = 0; i < warm; i++) begin
            chk("zvalid_warm", zv[d], 1'b0);
            tick();
        end
        chk("zvalid_run", zv[d], 1'b1);
        m[d] = adv(m[d], warm);
        chk("z_after_warm", z[d], m[d][ZW-1:0]);
    endtask

    task automatic handshake(input int d, input string tag);
        zr[d] = 1'b1;
        tick();
        zr[d] = 1'b0;
        m[d] = adv(m[d], 1);
        chk(tag, z[d], m[d][ZW-1:0]);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; rs[d] = 1'b0; zr[d] = 1'b0; seed[d] = '0; m[d] = '0;
        end
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Seed 1,0,0,0 with no warmup: valid one cycle after the 4th word.
        seed_all(0, 32'h1, 32'h0, 32'h0, 32'h0);
        warm_to_run(0, 0);
        chk("t1_z_is_one", z[0], 50'h1);
        chk("t1_seedready_run", sr[0], 1'b0);

        // Held output while the consumer stalls.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_z", z[0], m[0][ZW-1:0]);
            chk("t3_hold_zvalid", zv[0], 1'b1);
        end
        // Back-to-back consumption, one word per cycle.
        zr[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            m[0] = adv(m[0], 1);
            chk("t3_stream_z", z[0], m[0][ZW-1:0]);
        end
        zr[0] = 1'b0;

        // All-zero seed turns into state 1; long run with random ZReady.
        reset_pulse("rst_a");
        seed_all(0, 32'h0, 32'h0, 32'h0, 32'h0);
        warm_to_run(0, 0);
        chk("t2_z_is_one", z[0], 50'h1);
        for (int i = 0; i < 1000; i++) begin
            logic take;
            take  = 1'($urandom_range(0, 1));
            zr[0] = take;
            tick();
            if (take) m[0] = adv(m[0], 1);
            if (m[0] == '0) begin
                n_checks++;
                n_err++;
                $error("FAIL t2_model_zero observed=0 expected=nonzero");
            end
            chk("t2_rand_z", z[0], m[0][ZW-1:0]);
        end
        zr[0] = 1'b0;

        // Warmup latency and forced reseed after 3 words.
        seed_all(1, $urandom, $urandom, $urandom, $urandom);
        warm_to_run(1, W1);
        handshake(1, "t4_word1");
        chk("t4_zvalid_1", zv[1], 1'b1);
        handshake(1, "t4_word2");
        chk("t4_zvalid_2", zv[1], 1'b1);
        handshake(1, "t4_word3");
        chk("t4_exh_zvalid", zv[1], 1'b0);
        chk("t4_exh_reseedreq", rq[1], 1'b1);
        chk("t4_exh_seedready", sr[1], 1'b1);
        tick();
        chk("t4_exh_stays", rq[1], 1'b1);
        seed_all(1, $urandom, $urandom, $urandom, $urandom);
        chk("t4_reseedreq_clear", rq[1], 1'b0);
        warm_to_run(1, W1);

        // Reseed request together with a handshake.
        zr[1] = 1'b1;
        rs[1] = 1'b1;
        tick();
        zr[1] = 1'b0;
        rs[1] = 1'b0;
        m[1] = adv(m[1], 1);
        chk("t5_z_advanced", z[1], m[1][ZW-1:0]);
        chk("t5_zvalid_off", zv[1], 1'b0);
        chk("t5_seedready", sr[1], 1'b1);
        chk("t5_reseedreq", rq[1], 1'b0);
        seed_all(1, $urandom, $urandom, $urandom, $urandom);
        warm_to_run(1, W1);
        // Word budget restarts after the reseed.
        handshake(1, "t5_word1");
        chk("t5_budget_1", zv[1], 1'b1);
        handshake(1, "t5_word2");
        chk("t5_budget_2", zv[1], 1'b1);
        handshake(1, "t5_word3");
        chk("t5_budget_exh", rq[1], 1'b1);

        // Reset in the middle of warmup.
        seed_all(1, $urandom, $urandom, $urandom, $urandom);
        tick();
        tick();
        chk("t6_in_warm", zv[1], 1'b0);
        reset_pulse("rst_warm");
        // Reset while running.
        seed_all(1, $urandom, $urandom, $urandom, $urandom);
        warm_to_run(1, W1);
        handshake(1, "t6_word1");
        reset_pulse("rst_run");
        tick();
        check_reset_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
